// File: rtl/soundweb_tx_scheduler_pkg.sv
// Shared Soundweb framing definitions: control bytes, body field layout,
// scheduler state encoding and the byte-level helpers used by the scheduler.
package soundweb_tx_scheduler_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t STX        = 8'h02;
    localparam byte_t ETX        = 8'h03;
    localparam byte_t ACK        = 8'h06;
    localparam byte_t NAK        = 8'h15;
    localparam byte_t ESC        = 8'h1B;
    localparam byte_t ESC_OFFSET = 8'h80;

    // Body field indices, in transmit order.
    localparam int unsigned COMMAND   = 0;
    localparam int unsigned ADDRESS_0 = 1;
    localparam int unsigned ADDRESS_1 = 2;
    localparam int unsigned ADDRESS_2 = 3;
    localparam int unsigned ADDRESS_3 = 4;
    localparam int unsigned ADDRESS_4 = 5;
    localparam int unsigned ADDRESS_5 = 6;
    localparam int unsigned SV_0      = 7;
    localparam int unsigned SV_1      = 8;
    localparam int unsigned DATA_0    = 9;
    localparam int unsigned DATA_1    = 10;
    localparam int unsigned DATA_2    = 11;
    localparam int unsigned DATA_3    = 12;

    localparam int unsigned BODY_LEN = 13;
    localparam int unsigned MSG_W    = BODY_LEN * 8;

    // Byte k of a message lives at msg[k].
    typedef logic [BODY_LEN-1:0][7:0] msg_t;

    typedef enum logic [2:0] {
        StIdle,
        StSendStx,
        StSendBody,
        StSendEsc2,
        StSendCsum,
        StSendEtx,
        StWaitAck
    } tx_state_e;

    // Bytes that must never appear raw inside a frame body or checksum.
    function automatic logic is_reserved_byte(input byte_t b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

    // Frame checksum: XOR of the unescaped body bytes.
    function automatic byte_t body_xor(input msg_t m);
        byte_t x;
        x = '0;
        for (int unsigned k = 0; k < BODY_LEN; k++) begin
            x = x ^ m[k];
        end
        return x;
    endfunction

endpackage

// File: rtl/soundweb_tx_scheduler_if.sv
// Byte-wide UART link: TX valid/ready toward the transmitter, RX strobe from the receiver.
interface soundweb_tx_scheduler_if;
    import soundweb_tx_scheduler_pkg::*;

    byte_t tx_data;
    logic  tx_valid;
    logic  tx_ready;
    byte_t rx_data;
    logic  rx_valid;

    // Scheduler side.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    // UART side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/soundweb_rr_arbiter.sv
// Round-robin grant: first requester at or above the pointer wins, wrapping around.
// The pointer only moves when the grant is actually accepted.
module soundweb_rr_arbiter
    import soundweb_tx_scheduler_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic         valid_o,
    output logic [N-1:0] grant_o,
    output logic [2:0]   grant_idx_o
);

    logic [2:0] ptr_q, ptr_d;

    // Two passes: indices at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        valid_o     = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_o && req_i[i] && (3'(i) >= ptr_q)) begin
                valid_o     = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = 3'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o     = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = 3'(i);
            end
        end
    end

    // Next pointer is one past the accepted grant, modulo N.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && valid_o) begin
            ptr_d = (grant_idx_o == 3'(N - 1)) ? 3'd0 : grant_idx_o + 3'd1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/soundweb_tx_scheduler.sv
// Shares one Soundweb TX link between N_REQ sources: arbitrates, latches the granted
// message, sends STX / escaped body / escaped checksum / ETX, then waits for ACK and
// retransmits on NAK or timeout.
module soundweb_tx_scheduler
    import soundweb_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned ACK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*MSG_W-1:0]  req_message,
    output logic [N_REQ-1:0]        req_ready,
    soundweb_tx_scheduler_if.master uart,
    output logic                    busy,
    output logic                    done,
    output logic                    done_ok,
    output logic [2:0]              done_id
);

    localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);
    // Byte index used while the checksum is on the wire.
    localparam logic [3:0]        CsumIdx     = 4'(BODY_LEN);

    tx_state_e         state_q;
    msg_t              msg_q;
    logic [2:0]        id_q;
    logic [3:0]        idx_q;
    logic [RetryW-1:0] retry_q;
    logic [TimerW-1:0] timer_q;
    logic              tx_valid_q;
    byte_t             tx_data_q;
    logic              done_q;
    logic              done_ok_q;
    logic [2:0]        done_id_q;

    logic              arb_valid;
    logic [N_REQ-1:0]  arb_grant;
    logic [2:0]        arb_idx;
    logic              accept;
    msg_t              sel_msg;

    byte_t             csum;
    byte_t             cur_byte;
    logic [3:0]        adv_idx;
    byte_t             adv_byte;
    byte_t             adv_data;
    tx_state_e         adv_state;
    logic              xfer;
    logic              rx_ack;
    logic              rx_nak;
    logic              timeout;
    logic              can_retry;

    soundweb_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req_valid),
        .accept_i    (accept),
        .valid_o     (arb_valid),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    // Grant is taken only from IDLE; req_ready is the single-cycle accept strobe.
    always_comb begin
        accept    = (state_q == StIdle) && arb_valid && !reset;
        req_ready = accept ? arb_grant : '0;
        sel_msg   = '0;
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (arb_grant[r]) begin
                sel_msg = req_message[r*MSG_W +: MSG_W];
            end
        end
    end

    // Byte selection: the byte currently being sent and the next one to present.
    always_comb begin
        csum     = body_xor(msg_q);
        cur_byte = csum;
        if (idx_q < CsumIdx) begin
            cur_byte = msg_q[idx_q];
        end
        adv_idx  = (state_q == StSendStx) ? 4'd0 : idx_q + 4'd1;
        adv_byte = csum;
        if (adv_idx < CsumIdx) begin
            adv_byte = msg_q[adv_idx];
        end
        adv_data  = is_reserved_byte(adv_byte) ? ESC : adv_byte;
        adv_state = (adv_idx < CsumIdx) ? StSendBody : StSendCsum;

        xfer      = tx_valid_q && uart.tx_ready;
        rx_ack    = uart.rx_valid && (uart.rx_data == ACK);
        rx_nak    = uart.rx_valid && (uart.rx_data == NAK);
        timeout   = (timer_q == TimeoutLast);
        can_retry = (retry_q < RetryMax);
    end

    // Transaction FSM with registered link and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            msg_q      <= '0;
            id_q       <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            done_ok_q  <= 1'b0;
            done_id_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        msg_q      <= sel_msg;
                        id_q       <= arb_idx;
                        retry_q    <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= STX;
                        state_q    <= StSendStx;
                    end
                end
                StSendStx: begin
                    if (xfer) begin
                        idx_q     <= adv_idx;
                        tx_data_q <= adv_data;
                        state_q   <= adv_state;
                    end
                end
                StSendBody: begin
                    if (xfer) begin
                        if (is_reserved_byte(cur_byte)) begin
                            tx_data_q <= cur_byte + ESC_OFFSET;
                            state_q   <= StSendEsc2;
                        end else begin
                            idx_q     <= adv_idx;
                            tx_data_q <= adv_data;
                            state_q   <= adv_state;
                        end
                    end
                end
                StSendEsc2: begin
                    if (xfer) begin
                        if (idx_q == CsumIdx) begin
                            tx_data_q <= ETX;
                            state_q   <= StSendEtx;
                        end else begin
                            idx_q     <= adv_idx;
                            tx_data_q <= adv_data;
                            state_q   <= adv_state;
                        end
                    end
                end
                StSendCsum: begin
                    if (xfer) begin
                        if (is_reserved_byte(csum)) begin
                            tx_data_q <= csum + ESC_OFFSET;
                            state_q   <= StSendEsc2;
                        end else begin
                            tx_data_q <= ETX;
                            state_q   <= StSendEtx;
                        end
                    end
                end
                StSendEtx: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    timer_q <= timer_q + 1'b1;
                    // ACK wins over a simultaneous timeout.
                    if (rx_ack) begin
                        done_q    <= 1'b1;
                        done_ok_q <= 1'b1;
                        done_id_q <= id_q;
                        state_q   <= StIdle;
                    end else if (rx_nak || timeout) begin
                        if (can_retry) begin
                            retry_q    <= retry_q + 1'b1;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= STX;
                            state_q    <= StSendStx;
                        end else begin
                            done_q    <= 1'b1;
                            done_ok_q <= 1'b0;
                            done_id_q <= id_q;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign uart.tx_valid = tx_valid_q;
    assign uart.tx_data  = tx_data_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign done_ok       = done_ok_q;
    assign done_id       = done_id_q;

endmodule

// File: tb/tb_soundweb_tx_scheduler.sv
// Bench for soundweb_tx_scheduler: directed and random transactions checked against a
// frame-building reference model and a round-robin pointer model.
module tb_soundweb_tx_scheduler;

    localparam int unsigned NR = 2;
    localparam int unsigned T  = 20;
    localparam int unsigned MR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*104-1:0] req_message;
    logic [NR-1:0]    req_ready;
    logic             busy, done, done_ok;
    logic [2:0]       done_id;

    soundweb_tx_scheduler_if uart_if ();

    soundweb_tx_scheduler #(
        .N_REQ       (NR),
        .ACK_TIMEOUT (T),
        .MAX_RETRY   (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_message (req_message),
        .req_ready   (req_ready),
        .uart        (uart_if),
        .busy        (busy),
        .done        (done),
        .done_ok     (done_ok),
        .done_id     (done_id)
    );

    always #5 clk = ~clk;

    // UART ready: fixed level, or random back-pressure when stall_mode is set.
    logic stall_mode = 1'b0;
    logic ready_level = 1'b1;
    logic rnd_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end
    assign uart_if.tx_ready = stall_mode ? rnd_ready : ready_level;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Link monitor, sampled on the falling edge.
    logic [7:0]    cur_q[$];
    logic [7:0]    last_frame[$];
    logic [NR-1:0] grant_log[$];
    int frames_done = 0;
    int done_cnt = 0;
    int grant_cyc = 0, stx_cyc = 0, etx_cyc = 0;
    logic last_ok = 1'b0;
    logic [2:0] last_id = '0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            cur_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (req_ready != '0) begin
                grant_log.push_back(req_ready);
                grant_cyc = cyc;
            end
            if (uart_if.tx_valid && !prev_valid) stx_cyc = cyc;
            prev_valid = uart_if.tx_valid;
            if (uart_if.tx_valid && uart_if.tx_ready) begin
                cur_q.push_back(uart_if.tx_data);
                if (uart_if.tx_data == 8'h03) begin
                    last_frame = cur_q;
                    cur_q.delete();
                    frames_done++;
                    etx_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                last_ok = done_ok;
                last_id = done_id;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame model.
    logic [7:0] exp_q[$];

    function automatic void push_esc(input logic [7:0] b);
        if (b inside {8'h02, 8'h03, 8'h06, 8'h15, 8'h1B}) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back(b + 8'h80);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    task automatic build_expected(input logic [103:0] m);
        logic [7:0] cs;
        exp_q.delete();
        exp_q.push_back(8'h02);
        cs = 8'h00;
        for (int k = 0; k < 13; k++) begin
            cs = cs ^ m[k*8 +: 8];
            push_esc(m[k*8 +: 8]);
        end
        push_esc(cs);
        exp_q.push_back(8'h03);
    endtask

    task automatic check_frame(input string tag, input logic [103:0] m);
        build_expected(m);
        check({tag, "_len"}, last_frame.size(), exp_q.size());
        check({tag, "_len_range"}, (last_frame.size() >= 16) && (last_frame.size() <= 30), 1);
        for (int i = 0; i < exp_q.size() && i < last_frame.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), last_frame[i], exp_q[i]);
        end
    endtask

    function automatic logic [103:0] rand_msg();
        logic [7:0] rsv [5] = '{8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
        logic [103:0] m;
        for (int k = 0; k < 13; k++) begin
            if ($urandom_range(0, 3) == 0) m[k*8 +: 8] = rsv[$urandom_range(0, 4)];
            else m[k*8 +: 8] = 8'($urandom);
        end
        return m;
    endfunction

    task automatic start_req(input int who, input logic [103:0] m);
        @(posedge clk); #2;
        req_message[who*104 +: 104] = m;
        req_valid[who] = 1'b1;
    endtask

    task automatic drop_req(input int who);
        @(posedge clk); #2;
        req_valid[who] = 1'b0;
    endtask

    task automatic wait_grant(input int n);
        int k = 0;
        while (grant_log.size() < n && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("grant_arrival", grant_log.size() >= n, 1);
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check("frame_arrival", frames_done >= n, 1);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_arrival", done_cnt >= n, 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat (2) @(posedge clk);
        #2;
        uart_if.rx_valid = 1'b1;
        uart_if.rx_data  = b;
        @(posedge clk); #2;
        uart_if.rx_valid = 1'b0;
    endtask

    initial begin
        logic [103:0] m, m0, m1;
        logic [7:0] held;
        int nf, nd, ng, who, e2, ptr, k;

        reset = 1'b1;
        req_valid = '0;
        req_message = '0;
        uart_if.rx_valid = 1'b0;
        uart_if.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk); #1;
        check("rst_tx_valid", uart_if.tx_valid, 0);
        check("rst_tx_data", uart_if.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_ok", done_ok, 0);
        check("rst_done_id", done_id, 0);
        check("rst_req_ready", req_ready, 0);
        nf = 0;

        // Plain frame from requester 0.
        m = '0;
        m[7:0] = 8'h88;
        m[103:96] = 8'h01;
        start_req(0, m);
        wait_grant(1);
        drop_req(0);
        wait_frames(nf + 1); nf++;
        check("stx_latency", stx_cyc - grant_cyc, 1);
        check_frame("plain", m);
        check("plain_len16", last_frame.size(), 16);
        check("plain_csum", last_frame[14], 8'h89);
        send_rx(8'h06);
        wait_done(1);
        check("plain_ok", last_ok, 1);
        check("plain_id", last_id, 0);

        // Body escape, with back-pressure and a stray ACK while the frame is going out.
        stall_mode = 1'b1;
        m = '0;
        m[7:0] = 8'h8D;
        m[103:96] = 8'h02;
        start_req(0, m);
        wait_grant(2);
        drop_req(0);
        uart_if.rx_valid = 1'b1;
        uart_if.rx_data = 8'h06;
        @(posedge clk); #2;
        uart_if.rx_valid = 1'b0;
        wait_frames(nf + 1); nf++;
        check("stray_ack_ignored", done_cnt, 1);
        check_frame("body_esc", m);
        check("body_esc_b13", last_frame[13], 8'h1B);
        check("body_esc_b14", last_frame[14], 8'h82);
        check("body_esc_csum", last_frame[15], 8'h8F);
        send_rx(8'h06);
        wait_done(2);
        check("body_esc_ok", last_ok, 1);

        // Checksum escape: 0x88 ^ 0x8E = 0x06.
        m = '0;
        m[7:0] = 8'h88;
        m[103:96] = 8'h8E;
        start_req(0, m);
        wait_grant(3);
        drop_req(0);
        wait_frames(nf + 1); nf++;
        check_frame("csum_esc", m);
        check("csum_esc_b14", last_frame[14], 8'h1B);
        check("csum_esc_b15", last_frame[15], 8'h86);
        check("csum_esc_etx", last_frame[16], 8'h03);
        send_rx(8'h06);
        wait_done(3);

        // Random single-requester transactions.
        for (int t = 0; t < 4; t++) begin
            who = $urandom_range(0, NR - 1);
            m = rand_msg();
            ng = grant_log.size();
            nd = done_cnt;
            start_req(who, m);
            wait_grant(ng + 1);
            check("rand_grant", grant_log[grant_log.size() - 1], NR'(1) << who);
            drop_req(who);
            wait_frames(nf + 1); nf++;
            check_frame($sformatf("rand%0d", t), m);
            send_rx(8'h06);
            wait_done(nd + 1);
            check("rand_ok", last_ok, 1);
            check("rand_id", last_id, who);
        end

        // Arbitration: both requesters pending continuously from a fresh pointer.
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        ptr = 0;
        m0 = rand_msg();
        m1 = rand_msg();
        ng = grant_log.size();
        @(posedge clk); #2;
        req_message = {m1, m0};
        req_valid = 2'b11;
        for (int t = 0; t < 3; t++) begin
            nd = done_cnt;
            wait_frames(nf + 1); nf++;
            who = ptr;
            check("arb_onehot", $onehot(grant_log[grant_log.size() - 1]), 1);
            check("arb_grant", grant_log[grant_log.size() - 1], NR'(1) << who);
            check_frame($sformatf("arb%0d", t), (who == 0) ? m0 : m1);
            ptr = (who + 1) % NR;
            repeat (2) @(posedge clk);
            #2;
            if (t == 2) req_valid = '0;
            uart_if.rx_valid = 1'b1;
            uart_if.rx_data = 8'h06;
            @(posedge clk); #2;
            uart_if.rx_valid = 1'b0;
            wait_done(nd + 1);
            check("arb_id", last_id, who);
        end
        repeat (10) @(posedge clk);
        check("arb_grant_count", grant_log.size() - ng, 3);
        check("arb_grant_seq", {grant_log[ng], grant_log[ng+1], grant_log[ng+2]}, 6'b01_10_01);

        // Retry: NAK, then silence (with an unrelated byte), then silence -> failure.
        m = rand_msg();
        ng = grant_log.size();
        nd = done_cnt;
        start_req(1, m);
        wait_grant(ng + 1);
        drop_req(1);
        wait_frames(nf + 1); nf++;
        check_frame("retry_a1", m);
        send_rx(8'h15);
        wait_frames(nf + 1); nf++;
        check_frame("retry_a2", m);
        e2 = etx_cyc;
        send_rx(8'h55);
        wait_frames(nf + 1); nf++;
        check("timeout_gap", stx_cyc - e2, T + 1);
        check_frame("retry_a3", m);
        check("no_early_done", done_cnt, nd);
        wait_done(nd + 1);
        check("retry_fail_ok", last_ok, 0);
        check("retry_fail_id", last_id, 1);
        repeat (T + 40) @(posedge clk);
        check("no_fourth_frame", frames_done, nf);
        check("retry_single_done", done_cnt, nd + 1);

        // ACK arriving in the very cycle the timeout expires.
        stall_mode = 1'b0;
        m = rand_msg();
        ng = grant_log.size();
        nd = done_cnt;
        start_req(0, m);
        wait_grant(ng + 1);
        drop_req(0);
        wait_frames(nf + 1); nf++;
        repeat (T) @(posedge clk);
        #2;
        uart_if.rx_valid = 1'b1;
        uart_if.rx_data = 8'h06;
        @(posedge clk); #2;
        uart_if.rx_valid = 1'b0;
        wait_done(nd + 1);
        check("ack_at_timeout_ok", last_ok, 1);
        repeat (T + 10) @(posedge clk);
        check("ack_at_timeout_no_resend", frames_done, nf);

        // Stall mid-body, then reset.
        m = rand_msg();
        ng = grant_log.size();
        nd = done_cnt;
        start_req(0, m);
        wait_grant(ng + 1);
        drop_req(0);
        k = 0;
        while (cur_q.size() < 5 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        ready_level = 1'b0;
        held = uart_if.tx_data;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("stall_valid", uart_if.tx_valid, 1);
            check("stall_data", uart_if.tx_data, held);
        end
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        ready_level = 1'b1;
        @(negedge clk); #1;
        check("post_rst_tx_valid", uart_if.tx_valid, 0);
        check("post_rst_busy", busy, 0);
        repeat (40) @(posedge clk);
        check("post_rst_no_done", done_cnt, nd);
        check("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
